// File: rtl/arc4_key_search.sv
// ARC4 key-search controller: launches one decrypt per candidate
// key and scans the plaintext for a fully printable message.
module arc4_key_search #(
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_STEP  = 24'h000001,
  parameter logic [23:0] KEY_LAST  = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic [23:0] key,
  output logic        key_valid,
  output logic        arc4_en,
  input  logic        arc4_rdy,
  output logic        pt_chk_sel,
  output logic [7:0]  pt_chk_addr,
  input  logic [7:0]  pt_rddata
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_LO,
    S_WAIT_HI,
    S_RD_LEN,
    S_LEN_WAIT,
    S_CHECK,
    S_NEXT,
    S_FOUND,
    S_EXHAUST
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  len;
  logic [8:0]  idx;
  logic [24:0] key_sum;
  logic        exhaust;
  logic        printable;
  logic        last_byte;

  assign key_sum   = {1'b0, key} + {1'b0, KEY_STEP};
  assign exhaust   = key_sum > {1'b0, KEY_LAST};
  assign printable = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);
  assign last_byte = idx == {1'b0, len};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Candidate key, result flag and scan bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key       <= KEY_START;
      key_valid <= 1'b0;
      len       <= 8'h00;
      idx       <= 9'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (en) begin
            key       <= KEY_START;
            key_valid <= 1'b0;
          end
        end
        S_LEN_WAIT: begin
          len <= pt_rddata;
          idx <= 9'd1;
        end
        S_CHECK: begin
          if (!last_byte) begin
            idx <= idx + 9'd1;
          end
        end
        S_NEXT: begin
          if (!exhaust) begin
            key <= key_sum[23:0];
          end
        end
        S_FOUND:   key_valid <= 1'b1;
        S_EXHAUST: key_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Next state and Moore/Mealy outputs; reads are pipelined in CHECK
  always_comb begin
    state_nx    = state;
    rdy         = 1'b0;
    arc4_en     = 1'b0;
    pt_chk_sel  = 1'b0;
    pt_chk_addr = 8'h00;
    unique case (state)
      S_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          state_nx = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (arc4_rdy) begin
          arc4_en  = 1'b1;
          state_nx = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!arc4_rdy) begin
          state_nx = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (arc4_rdy) begin
          state_nx = S_RD_LEN;
        end
      end
      S_RD_LEN: begin
        pt_chk_sel = 1'b1;
        state_nx   = S_LEN_WAIT;
      end
      S_LEN_WAIT: begin
        pt_chk_sel  = 1'b1;
        pt_chk_addr = 8'd1;
        state_nx    = (pt_rddata == 8'h00) ? S_FOUND : S_CHECK;
      end
      S_CHECK: begin
        pt_chk_sel  = 1'b1;
        pt_chk_addr = last_byte ? idx[7:0] : idx[7:0] + 8'd1;
        if (!printable) begin
          state_nx = S_NEXT;
        end else if (last_byte) begin
          state_nx = S_FOUND;
        end
      end
      S_NEXT: begin
        state_nx = exhaust ? S_EXHAUST : S_LAUNCH;
      end
      S_FOUND:   state_nx = S_IDLE;
      S_EXHAUST: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_arc4_key_search.sv
// Bench for arc4_key_search: two instances (default sweep and a
// stepped sweep near the top of key space) against an ARC4 core model.
module tb_arc4_key_search;

  logic        clk;
  logic        rst_n;
  logic        en     [2];
  logic        rdy    [2];
  logic [23:0] key    [2];
  logic        kv     [2];
  logic        aen    [2];
  logic        crdy   [2];
  logic        sel    [2];
  logic [7:0]  addr   [2];
  logic [7:0]  rddata [2];

  logic [7:0]  mem    [2][256];
  int          busy   [2];
  logic [23:0] ckey   [2];
  int          scen   [2];

  int          pulses [2];
  int          nidx   [2];
  logic [23:0] cur    [2];
  logic [7:0]  addr_q [$];
  logic [7:0]  prev_q [$];

  int checks;
  int failures;

  arc4_key_search #(
    .KEY_START(24'h000000),
    .KEY_STEP (24'h000001),
    .KEY_LAST (24'hFFFFFF)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]),
    .key(key[0]), .key_valid(kv[0]), .arc4_en(aen[0]),
    .arc4_rdy(crdy[0]), .pt_chk_sel(sel[0]),
    .pt_chk_addr(addr[0]), .pt_rddata(rddata[0])
  );

  arc4_key_search #(
    .KEY_START(24'hFFFFFD),
    .KEY_STEP (24'h000002),
    .KEY_LAST (24'hFFFFFF)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]),
    .key(key[1]), .key_valid(kv[1]), .arc4_en(aen[1]),
    .arc4_rdy(crdy[1]), .pt_chk_sel(sel[1]),
    .pt_chk_addr(addr[1]), .pt_rddata(rddata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] start_of(input int i);
    return (i == 1) ? 24'hFFFFFD : 24'h000000;
  endfunction

  function automatic logic [23:0] step_of(input int i);
    return (i == 1) ? 24'h000002 : 24'h000001;
  endfunction

  // Plaintext the ARC4 core "produces" for a key, per scenario.
  function automatic logic [7:0] pt_byte(input int sc,
                                         input logic [23:0] k,
                                         input int j);
    logic [7:0] r;
    r = 8'h00;
    case (sc)
      0: case (j)
           0: r = 8'd3;
           1: r = 8'h48;
           2: r = (k == 24'd3) ? 8'h69 : 8'h01;
           3: r = 8'h21;
           default: r = 8'h00;
         endcase
      1: if (k == 24'd0) begin
           if (j == 0) r = 8'd10;
           else if (j == 2) r = 8'h1F;
           else if (j <= 10) r = 8'h41;
         end else begin
           if (j == 0) r = 8'd1;
           else if (j == 1) r = 8'h5A;
         end
      2: if (j == 0) r = 8'd2;
         else if (j == 1) r = (k == 24'd1) ? 8'h19 : 8'h20;
         else if (j == 2) r = (k == 24'd0) ? 8'h7F : 8'h7E;
      3: r = 8'h00;
      5: r = (j == 0) ? 8'd255 : 8'h7E;
      default: if (j == 0) r = 8'd1;
               else if (j == 1) r = 8'h80;
    endcase
    return r;
  endfunction

  // Reference search: walk candidates, first fully printable wins.
  function automatic void ref_search(input int sc,
                                     input logic [23:0] start,
                                     input logic [23:0] step,
                                     input logic [23:0] last,
                                     output logic ok,
                                     output logic [23:0] fk,
                                     output int n);
    logic [24:0] k;
    logic [7:0]  ln;
    logic [7:0]  b;
    logic        good;
    k  = {1'b0, start};
    ok = 1'b0;
    fk = start;
    n  = 0;
    for (int it = 0; it < 64; it++) begin
      n++;
      fk   = k[23:0];
      ln   = pt_byte(sc, fk, 0);
      good = 1'b1;
      for (int j = 1; j <= int'(ln); j++) begin
        b = pt_byte(sc, fk, j);
        if (b < 8'h20 || b > 8'h7E) good = 1'b0;
      end
      if (good) begin
        ok = 1'b1;
        return;
      end
      k = k + {1'b0, step};
      if (k > {1'b0, last}) return;
    end
  endfunction

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural ARC4 core: busy a few cycles, then writes plaintext
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rddata[i] <= mem[i][addr[i]];
      if (!rst_n) begin
        crdy[i] <= 1'b1;
        busy[i] <= 0;
      end else if (aen[i]) begin
        crdy[i] <= 1'b0;
        busy[i] <= 4;
        ckey[i] <= key[i];
      end else if (busy[i] == 1) begin
        for (int j = 0; j < 256; j++)
          mem[i][j] <= pt_byte(scen[i], ckey[i], j);
        crdy[i] <= 1'b1;
        busy[i] <= 0;
      end else if (busy[i] > 0) begin
        busy[i] <= busy[i] - 1;
      end
    end
  end

  // Per-cycle compare: candidate order, key stability, port ownership
  initial begin
    for (int i = 0; i < 2; i++) begin
      pulses[i] = 0;
      nidx[i]   = 0;
      cur[i]    = 24'h0;
    end
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          if (en[i] && rdy[i]) begin
            pulses[i] = 0;
            nidx[i]   = 0;
          end
          if (aen[i]) begin
            chk($sformatf("cand%0d", i), key[i],
                24'(start_of(i) + nidx[i] * step_of(i)));
            chk($sformatf("aen_rdy%0d", i), rdy[i], 0);
            nidx[i]++;
            pulses[i]++;
            cur[i] = key[i];
            if (i == 0) begin
              prev_q = addr_q;
              addr_q.delete();
            end
          end
          if (sel[i]) begin
            chk($sformatf("key_stable%0d", i), key[i], cur[i]);
            chk($sformatf("sel_rdy%0d", i), rdy[i], 0);
            if (i == 0) addr_q.push_back(addr[0]);
          end
        end
      end
    end
  end

  task automatic run(input int i, input int sc, input longint lk,
                     input longint lok, input longint ln,
                     input string nm);
    logic        ok;
    logic [23:0] fk;
    int          n;
    logic        done;
    ref_search(sc, start_of(i), step_of(i), 24'hFFFFFF, ok, fk, n);
    chk({nm, "_model_key"}, fk, lk);
    chk({nm, "_model_ok"}, ok, lok);
    chk({nm, "_model_n"}, n, ln);
    scen[i] = sc;
    @(posedge clk);
    #1 en[i] = 1'b1;
    @(posedge clk);
    #1 en[i] = 1'b0;
    chk({nm, "_busy"}, rdy[i], 0);
    done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      done = rdy[i];
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_key"}, key[i], fk);
    chk({nm, "_valid"}, kv[i], ok);
    chk({nm, "_pulses"}, pulses[i], n);
  endtask

  initial begin
    int np;
    logic seen;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i]   = 1'b0;
      scen[i] = 4;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_rdy", rdy[0], 1);
      chk("idle_valid", kv[0], 0);
      chk("idle_key", key[0], 24'h000000);
      chk("idle_aen", aen[0], 0);
    end
    chk("idle_key_b", key[1], 24'hFFFFFD);

    run(0, 0, 24'h000003, 1, 4, "hi");
    chk("hi_nsel", addr_q.size(), 5);
    for (int j = 0; j < 4; j++)
      chk($sformatf("hi_addr%0d", j), addr_q[j], j);

    run(0, 1, 24'h000001, 1, 2, "abort");
    chk("abort_nsel", prev_q.size(), 4);
    chk("abort_addr2", prev_q[2], 2);

    run(0, 2, 24'h000002, 1, 3, "bound");
    run(0, 3, 24'h000000, 1, 1, "len0");
    chk("len0_nsel", addr_q.size(), 2);
    run(0, 5, 24'h000000, 1, 1, "len255");
    chk("len255_nsel", addr_q.size(), 257);
    chk("len255_last", addr_q[256], 255);

    run(1, 4, 24'hFFFFFF, 0, 2, "exhaust");

    scen[0] = 0;
    @(posedge clk);
    #1 en[0] = 1'b1;
    @(posedge clk);
    #1 en[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = aen[0];
    end
    chk("mid_launch", seen, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rdy", rdy[0], 1);
    chk("mid_valid", kv[0], 0);
    chk("mid_key", key[0], 24'h000000);
    chk("mid_aen", aen[0], 0);
    chk("mid_sel", sel[0], 0);
    chk("mid_addr", addr[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    np = pulses[0];
    repeat (20) @(negedge clk);
    chk("mid_no_pulse", pulses[0], np);
    chk("mid_idle", rdy[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arc4_key_search.md
Name: arc4_key_search

Overview:
- Key-search controller that sits directly upstream of the ARC4 decrypt core.
- Steps through candidate 24-bit keys and, for each one, starts one decryption on the core.
- After each decryption it scans the plaintext memory for a fully printable message.
- Reports the first key that yields one; the top level muxes plaintext-memory read access between the core and this block.

Parameters:
KEY_START, 24'h000000, first candidate key
KEY_STEP, 24'h000001, increment between candidates (2 for dual-core split search)
KEY_LAST, 24'hFFFFFF, last candidate key allowed (inclusive)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
en  input  1  start request; sampled only while rdy=1
rdy  output  1  1 = idle and able to accept en
key  output  24  current candidate to the ARC4 core; holds found key once done
key_valid  output  1  1 = key holds a verified key (meaningful while rdy=1)
arc4_en  output  1  one-cycle start pulse to the ARC4 core
arc4_rdy  input  1  ARC4 core ready
pt_chk_sel  output  1  1 = this block owns the plaintext memory read port
pt_chk_addr  output  8  plaintext read address
pt_rddata  input  8  plaintext read data, synchronous RAM, 1-cycle latency

Behaviour:
- Reset (async, any state): go to IDLE.
  - rdy=1, key_valid=0, key=KEY_START, arc4_en=0, pt_chk_sel=0, pt_chk_addr=0.
  - Reset mid-search aborts without further arc4_en pulses.
- IDLE: rdy=1. On en=1:
  - key<=KEY_START, key_valid<=0, rdy<=0.
  - Go to LAUNCH.
  - en while rdy=0 is ignored.
- LAUNCH: wait for arc4_rdy=1, then drive arc4_en=1 for exactly one cycle and go to WAIT_LO.
- WAIT_LO: wait for arc4_rdy=0. This guards against sampling a stale ready; tolerates the core dropping rdy one cycle after en.
- WAIT_HI: wait for arc4_rdy=1 (decryption complete), then go to RD_LEN.
- RD_LEN: pt_chk_sel=1, pt_chk_addr=0. Next cycle (LEN_WAIT), latch len<=pt_rddata.
  - len=0: empty message counts as a match; go to FOUND.
- CHECK loop: byte index i runs 1..len.
  - Issue pt_chk_addr=i; compare pt_rddata one cycle later.
  - Printable means 8'h20 <= byte <= 8'h7E.
  - Any non-printable byte aborts the scan immediately; go to NEXT.
  - If i reaches len with all bytes printable, go to FOUND.
  - Addresses are pipelined: a new address is issued every cycle while the previous byte is compared, so a clean scan takes len+1 cycles after RD_LEN.
  - The one in-flight read after an abort is discarded.
  - i is 9 bits wide so len=255 terminates with no wrap.
- NEXT: pt_chk_sel=0.
  - Compute key+KEY_STEP in 25 bits.
  - If it carries out or exceeds KEY_LAST: go to EXHAUST.
  - Otherwise key<=next value; go to LAUNCH.
- FOUND: key_valid<=1, key held, rdy<=1; go to IDLE.
- EXHAUST: key_valid<=0, rdy<=1; go to IDLE. key holds the last tried value.
- key must stay stable from the arc4_en pulse until the CHECK loop ends.
- pt_chk_sel is 1 only in RD_LEN, LEN_WAIT and the CHECK states.
- Simultaneous en and rdy-deassert cannot occur: rdy falls on the cycle after en is accepted.

Test Plan:
- Reset idle: hold rst_n=0, release, then idle 5 cycles with en=0 -> rdy=1, key_valid=0, arc4_en never asserted, key=24'h000000.
- Match at key 24'h000003: behavioural ARC4 model writes pt as non-printable for keys 0–2 and "Hi!" (len 3) for key 3. Pulse en ->
  - exactly 4 arc4_en pulses;
  - final key=24'h000003, key_valid=1, rdy=1;
  - pt_chk_addr visits 0,1,2,3 on the last pass.
- Early abort: model writes len=10 with byte 2=8'h1F -> scan stops after address 2 (addr 3 may be issued then discarded); next arc4_en follows with key+1.
- Boundary chars: plaintext bytes 8'h20 and 8'h7E accepted; 8'h7F and 8'h19 rejected; len=0 accepted at the first key.
- Exhaustion: KEY_START=24'hFFFFFD, KEY_STEP=2, no match -> pulses for keys FFFFFD and FFFFFF only, then key_valid=0, rdy=1, key=24'hFFFFFF.
- Reset mid-search: assert rst_n=0 during WAIT_HI -> outputs reach reset values asynchronously; after release there are no arc4_en pulses until a new en.
